// File: rtl/mem_access_ctrl.sv
// Load/store access controller: checks alignment and funct3, drives one word-aligned memory access,
// extends load data, and aborts accesses whose memory response exceeds TIMEOUT cycles.
module mem_access_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_address,
  output logic        mem_read,
  output logic        mem_write,
  output logic [3:0]  mem_byte_enable,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_resp
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_e;

  localparam logic [15:0] LastWaitCycle = 16'(TIMEOUT - 1);

  state_e      state_q;
  logic [15:0] wait_cnt_q;
  logic [2:0]  funct3_q;
  logic [1:0]  offset_q;
  logic        write_q;
  logic        mem_read_q;
  logic        mem_write_q;
  logic        resp_valid_q;
  logic        resp_err_q;
  logic [31:0] resp_rdata_q;
  logic [31:0] mem_address_q;
  logic [3:0]  mem_byte_enable_q;
  logic [31:0] mem_wdata_q;

  logic        req_legal;
  logic        req_misaligned;
  logic        req_err;
  logic [3:0]  store_be;
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] load_data;

  assign req_ready       = (state_q == IDLE) & ~rst;
  assign resp_valid      = resp_valid_q;
  assign resp_rdata      = resp_rdata_q;
  assign resp_err        = resp_err_q;
  assign mem_address     = mem_address_q;
  assign mem_read        = mem_read_q;
  assign mem_write       = mem_write_q;
  assign mem_byte_enable = mem_byte_enable_q;
  assign mem_wdata       = mem_wdata_q;

  // funct3[1:0] encodes access size for both directions: 00 byte, 01 half, 10 word.
  always_comb begin
    req_legal      = 1'b0;
    req_misaligned = 1'b0;
    store_be       = 4'b1111;
    if (req_write) begin
      req_legal = req_funct3 inside {3'b000, 3'b001, 3'b010};
    end else begin
      req_legal = req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    end
    case (req_funct3[1:0])
      2'b01:   req_misaligned = req_addr[0];
      2'b10:   req_misaligned = (req_addr[1:0] != 2'b00);
      default: req_misaligned = 1'b0;
    endcase
    case (req_funct3[1:0])
      2'b00:   store_be = 4'b0001 << req_addr[1:0];
      2'b01:   store_be = 4'b0011 << req_addr[1:0];
      default: store_be = 4'b1111;
    endcase
    req_err = ~req_legal | req_misaligned;
  end

  always_comb begin
    load_byte = 8'h00;
    case (offset_q)
      2'd0: load_byte = mem_rdata[7:0];
      2'd1: load_byte = mem_rdata[15:8];
      2'd2: load_byte = mem_rdata[23:16];
      2'd3: load_byte = mem_rdata[31:24];
      default: load_byte = 8'h00;
    endcase
    load_half = offset_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (funct3_q)
      3'b000:  load_data = {{24{load_byte[7]}}, load_byte};
      3'b100:  load_data = {24'h0, load_byte};
      3'b001:  load_data = {{16{load_half[15]}}, load_half};
      3'b101:  load_data = {16'h0, load_half};
      default: load_data = mem_rdata;
    endcase
  end

  // mem_resp takes priority over the timeout when both land on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q           <= IDLE;
      wait_cnt_q        <= 16'h0;
      funct3_q          <= 3'b000;
      offset_q          <= 2'b00;
      write_q           <= 1'b0;
      mem_read_q        <= 1'b0;
      mem_write_q       <= 1'b0;
      resp_valid_q      <= 1'b0;
      resp_err_q        <= 1'b0;
      resp_rdata_q      <= 32'h0;
      mem_address_q     <= 32'h0;
      mem_byte_enable_q <= 4'b0000;
      mem_wdata_q       <= 32'h0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            funct3_q      <= req_funct3;
            offset_q      <= req_addr[1:0];
            write_q       <= req_write;
            wait_cnt_q    <= 16'h0;
            mem_address_q <= {req_addr[31:2], 2'b00};
            if (req_err) begin
              state_q      <= DONE;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
              resp_rdata_q <= 32'h0;
            end else if (req_write) begin
              state_q           <= WRITE;
              mem_write_q       <= 1'b1;
              mem_byte_enable_q <= store_be;
              mem_wdata_q       <= req_wdata << {req_addr[1:0], 3'b000};
            end else begin
              state_q           <= READ;
              mem_read_q        <= 1'b1;
              mem_byte_enable_q <= 4'b1111;
            end
          end
        end
        READ, WRITE: begin
          wait_cnt_q <= wait_cnt_q + 16'd1;
          if (mem_resp) begin
            state_q      <= DONE;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= write_q ? 32'h0 : load_data;
          end else if (wait_cnt_q == LastWaitCycle) begin
            state_q      <= DONE;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b1;
            resp_rdata_q <= 32'h0;
          end
        end
        DONE: begin
          state_q      <= IDLE;
          resp_valid_q <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: a reference model queues the expected response for every
// request and a monitor pops and compares it whenever resp_valid pulses.
module tb_mem_access_ctrl;

  localparam int Timeout = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_address;
  logic        mem_read;
  logic        mem_write;
  logic [3:0]  mem_byte_enable;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_resp;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    string       tag;
  } exp_t;

  exp_t expQ[$];
  int   checkCount = 0;
  int   passCount  = 0;

  mem_access_ctrl #(.TIMEOUT(Timeout)) dut (
    .clk             (clk),
    .rst             (rst),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_write       (req_write),
    .req_funct3      (req_funct3),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .resp_valid      (resp_valid),
    .resp_rdata      (resp_rdata),
    .resp_err        (resp_err),
    .mem_address     (mem_address),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_byte_enable (mem_byte_enable),
    .mem_wdata       (mem_wdata),
    .mem_rdata       (mem_rdata),
    .mem_resp        (mem_resp)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    end else begin
      passCount++;
    end
  endtask

  // Response monitor: every completion must match the oldest queued expectation.
  always @(negedge clk) begin
    if (resp_valid === 1'b1) begin
      if (expQ.size() == 0) begin
        checkOutput("unexpected resp_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        checkOutput({e.tag, " resp_err"}, {31'd0, resp_err}, {31'd0, e.err});
        checkOutput({e.tag, " resp_rdata"}, resp_rdata, e.rdata);
      end
    end
  end

  // respCycle: strobe cycle (1-based) in which mem_resp is given; 0 means never.
  task automatic applyStimulus(input string tag, input logic wr, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [31:0] rdata, input int respCycle);
    logic [1:0]  off;
    logic [1:0]  size;
    logic        legal;
    logic        accErr;
    logic [3:0]  expBe;
    logic [31:0] expWdata;
    logic [31:0] shifted;
    logic [31:0] loadVal;
    int          expStrobes;
    int          strobes;
    bit          respGiven;
    exp_t        e;

    off  = addr[1:0];
    size = f3[1:0];
    legal = wr ? (f3 <= 3'd2) : (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    accErr = !legal || (size == 2'd1 && off[0]) || (size == 2'd2 && off != 2'd0);
    if (!wr)                expBe = 4'hF;
    else if (size == 2'd0)  expBe = 4'b0001 << off;
    else if (size == 2'd1)  expBe = 4'b0011 << off;
    else                    expBe = 4'hF;
    expWdata = wdata << (8 * off);
    shifted  = rdata >> (8 * off);
    case (f3)
      3'd0:    loadVal = 32'($signed(shifted[7:0]));
      3'd4:    loadVal = {24'd0, shifted[7:0]};
      3'd1:    loadVal = 32'($signed(shifted[15:0]));
      3'd5:    loadVal = {16'd0, shifted[15:0]};
      default: loadVal = rdata;
    endcase
    respGiven = (respCycle >= 1 && respCycle <= Timeout);
    expStrobes = respGiven ? respCycle : Timeout;

    e.tag = tag;
    if (accErr || !respGiven) begin
      e.err   = 1'b1;
      e.rdata = 32'd0;
    end else begin
      e.err   = 1'b0;
      e.rdata = wr ? 32'd0 : loadVal;
    end
    expQ.push_back(e);

    @(negedge clk);
    checkOutput({tag, " req_ready"}, {31'd0, req_ready}, 32'd1);
    req_valid  = 1'b1;
    req_write  = wr;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wdata;
    @(posedge clk);
    #1 req_valid = 1'b0;
    req_addr  = 32'hDEAD_BEEF;
    req_wdata = $urandom;
    @(negedge clk);

    if (accErr) begin
      checkOutput({tag, " err strobes"}, {30'd0, mem_read, mem_write}, 32'd0);
      checkOutput({tag, " err latency"}, {31'd0, resp_valid}, 32'd1);
    end else begin
      strobes = 0;
      for (int k = 0; k < 3 * Timeout; k++) begin
        if (!(mem_read || mem_write)) break;
        strobes++;
        if (strobes == 1) begin
          checkOutput({tag, " strobe kind"}, {30'd0, mem_read, mem_write}, wr ? 32'd1 : 32'd2);
          checkOutput({tag, " mem_address"}, mem_address, {addr[31:2], 2'b00});
          checkOutput({tag, " byte_enable"}, {28'd0, mem_byte_enable}, {28'd0, expBe});
          if (wr) checkOutput({tag, " mem_wdata"}, mem_wdata, expWdata);
        end
        mem_resp  = (strobes == respCycle);
        mem_rdata = mem_resp ? rdata : $urandom;
        @(negedge clk);
        mem_resp  = 1'b0;
        mem_rdata = $urandom;
      end
      checkOutput({tag, " strobe cycles"}, 32'(strobes), 32'(expStrobes));
      checkOutput({tag, " resp latency"}, {31'd0, resp_valid}, 32'd1);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst        = 1'b1;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_funct3 = 3'd0;
    req_addr   = 32'd0;
    req_wdata  = 32'd0;
    mem_rdata  = 32'd0;
    mem_resp   = 1'b0;
    #1;
    checkOutput("reset req_ready", {31'd0, req_ready}, 32'd0);
    checkOutput("reset strobes", {30'd0, mem_read, mem_write}, 32'd0);
    checkOutput("reset resp", {30'd0, resp_valid, resp_err}, 32'd0);
    checkOutput("reset resp_rdata", resp_rdata, 32'd0);
    checkOutput("reset mem_address", mem_address, 32'd0);
    checkOutput("reset mem_wdata", mem_wdata, 32'd0);
    checkOutput("reset byte_enable", {28'd0, mem_byte_enable}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    applyStimulus("lb 1003",   1'b0, 3'b000, 32'h0000_1003, 32'h0,         32'h80FF_0000, 3);
    applyStimulus("lhu 2002",  1'b0, 3'b101, 32'h0000_2002, 32'h0,         32'hBEEF_1234, 1);
    applyStimulus("lh 2002",   1'b0, 3'b001, 32'h0000_2002, 32'h0,         32'hBEEF_1234, 2);
    applyStimulus("sh 3002",   1'b1, 3'b001, 32'h0000_3002, 32'h0000_ABCD, 32'h0,         2);
    applyStimulus("lw 4001",   1'b0, 3'b010, 32'h0000_4001, 32'h0,         32'h0,         1);
    applyStimulus("ld f3=011", 1'b0, 3'b011, 32'h0000_4000, 32'h0,         32'h0,         1);
    applyStimulus("lw timeout", 1'b0, 3'b010, 32'h0000_5000, 32'h0,        32'h1234_5678, 0);
    applyStimulus("lw resp@4", 1'b0, 3'b010, 32'h0000_5000, 32'h0,         32'h1234_5678, 4);
    applyStimulus("lbu 1001",  1'b0, 3'b100, 32'h0000_1001, 32'h0,         32'h0000_9C00, 1);
    applyStimulus("sw 7000",   1'b1, 3'b010, 32'h0000_7000, 32'hCAFE_F00D, 32'h0,         1);
    applyStimulus("sb 7003",   1'b1, 3'b000, 32'h0000_7003, 32'h0000_00AB, 32'h0,         3);
    applyStimulus("st f3=100", 1'b1, 3'b100, 32'h0000_7000, 32'h0,         32'h0,         1);
    applyStimulus("sh 3001",   1'b1, 3'b001, 32'h0000_3001, 32'h0,         32'h0,         1);
    applyStimulus("sw timeout", 1'b1, 3'b010, 32'h0000_7004, 32'h1111_2222, 32'h0,        0);

    // A memory response outside an access must not produce a completion.
    @(negedge clk);
    mem_resp = 1'b1;
    @(negedge clk);
    mem_resp = 1'b0;
    checkOutput("idle mem_resp ignored", {31'd0, resp_valid}, 32'd0);

    // Reset in the middle of a read aborts it without a response.
    req_valid  = 1'b1;
    req_write  = 1'b0;
    req_funct3 = 3'b010;
    req_addr   = 32'h0000_5000;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    checkOutput("pre-reset mem_read", {31'd0, mem_read}, 32'd1);
    #2 rst = 1'b1;
    #1;
    checkOutput("async reset mem_read", {31'd0, mem_read}, 32'd0);
    checkOutput("async reset req_ready", {31'd0, req_ready}, 32'd0);
    checkOutput("async reset mem_address", mem_address, 32'd0);
    @(negedge clk);
    mem_resp = 1'b1;
    @(negedge clk);
    mem_resp = 1'b0;
    rst = 1'b0;
    checkOutput("post-reset resp_valid", {31'd0, resp_valid}, 32'd0);
    applyStimulus("sb 6001",   1'b1, 3'b000, 32'h0000_6001, 32'h0000_005A, 32'h0,         1);

    for (int i = 0; i < 24; i++) begin
      logic [31:0] a;
      a = {20'd0, 8'($urandom_range(0, 255)), 2'b00, 2'($urandom_range(0, 3))};
      applyStimulus($sformatf("rand%0d", i), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                    a, $urandom, $urandom, $urandom_range(0, Timeout + 1));
    end

    repeat (2) @(negedge clk);
    checkOutput("scoreboard drained", 32'(expQ.size()), 32'd0);
    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 255: maximum cycles spent waiting for mem_resp before the access is aborted; legal range 1..65535.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 req_valid  input  1  core presents an access request.
REQ-005 req_ready  output  1  controller can accept a request this cycle.
REQ-006 req_write  input  1  1 = store, 0 = load.
REQ-007 req_funct3  input  3  load codes: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu; store codes: 000 sb, 001 sh, 010 sw.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_wdata  input  32  store data, right-aligned.
REQ-010 resp_valid  output  1  one-cycle completion pulse.
REQ-011 resp_rdata  output  32  extended load result.
REQ-012 resp_err  output  1  completion is an error (misaligned, illegal funct3, or timeout); qualified by resp_valid.
REQ-013 mem_address  output  32  word-aligned address: captured req_addr with bits [1:0] forced to 00.
REQ-014 mem_read  output  1  memory read strobe.
REQ-015 mem_write  output  1  memory write strobe.
REQ-016 mem_byte_enable  output  4  lane enables.
REQ-017 mem_wdata  output  32  lane-positioned store data.
REQ-018 mem_rdata  input  32  memory read word.
REQ-019 mem_resp  input  1  memory completion, one cycle.

Function
REQ-020 FSM states: IDLE, READ, WRITE, DONE; req_ready SHALL be 1 only in IDLE with rst low.
REQ-021 Accept occurs on a rising edge with req_valid & req_ready; req_write, req_funct3, req_addr, req_wdata are captured.
REQ-022 Error check at accept: lh/lhu/sh with addr[0]=1, lw/sw with addr[1:0]!=00, or any funct3 not listed in REQ-007 for the given direction -> transition IDLE->DONE with resp_err=1, resp_rdata=0, no memory strobe at any time.
REQ-023 Legal load -> IDLE->READ; legal store -> IDLE->WRITE.
REQ-024 mem_read = 1 exactly while in READ; mem_write = 1 exactly while in WRITE; both registered from state, never combinational on req_*.
REQ-025 READ: mem_byte_enable = 1111. WRITE: sb -> 0001<<addr[1:0], sh -> 0011<<addr[1:0], sw -> 1111; mem_wdata = req_wdata shifted left by 8*addr[1:0].
REQ-026 Load extraction at mem_resp: byte lane addr[1:0] (lb sign-extends bit 7 of the lane, lbu zero-extends); halfword lane addr[1] (lh sign-extends bit 15, lhu zero-extends); lw passes the full word.
REQ-027 mem_resp sampled high in READ/WRITE -> transition to DONE; load result registered into resp_rdata; stores set resp_rdata=0.
REQ-028 A 16-bit wait counter clears on entry to READ/WRITE and increments each cycle there; if it reaches TIMEOUT with mem_resp low -> transition to DONE with resp_err=1, resp_rdata=0, strobes drop.
REQ-029 mem_resp and timeout on the same edge: mem_resp wins, resp_err=0.
REQ-030 DONE lasts exactly one cycle with resp_valid=1, then -> IDLE; resp_rdata and resp_err hold until the next DONE.
REQ-031 mem_resp while in IDLE or DONE SHALL be ignored.
REQ-032 Latency: accept edge N; strobe high in cycle N+1; mem_resp sampled at edge M; resp_valid high in cycle M+1. Minimum total is 2 cycles, or 1 cycle for an error (resp_valid in cycle N+1).
REQ-033 Back-to-back operation: a new request is accepted in the IDLE cycle following DONE; throughput is at most one access per 3 cycles.

Reset
REQ-034 rst high immediately forces IDLE, clears the counter, and sets mem_read=0, mem_write=0, resp_valid=0, resp_err=0, resp_rdata=0, mem_address=0, mem_byte_enable=0, mem_wdata=0, req_ready=0.
REQ-035 Reset in the middle of a READ/WRITE SHALL abort the access with no response pulse; the first accept is possible on the first edge after rst falls.

Verification
REQ-036 lb, addr 0x1003, mem_rdata 0x80FF_0000, mem_resp 3 cycles after strobe -> mem_address 0x1000, resp_rdata 0xFFFF_FF80, resp_err=0.
REQ-037 lhu, addr 0x2002, mem_rdata 0xBEEF_1234 -> resp_rdata 0x0000_BEEF; lh at the same address -> 0xFFFF_BEEF.
REQ-038 sh, addr 0x3002, wdata 0x0000_ABCD -> mem_write=1, byte_enable 1100, mem_wdata 0xABCD_0000, resp_valid with resp_err=0.
REQ-039 lw at 0x4001 -> resp_valid in cycle N+1 with resp_err=1, mem_read never asserted; funct3=011 gives the same result.
REQ-040 TIMEOUT=4, lw at 0x5000, no mem_resp -> mem_read high for exactly 4 cycles, then resp_err=1; a second run with mem_resp on the 4th cycle -> resp_err=0.
REQ-041 rst pulsed during READ -> mem_read drops asynchronously, no resp_valid; a new sb to 0x6001 (wdata 0x5A) -> byte_enable 0010, mem_wdata 0x0000_5A00.
